// File: rtl/pid_fan_pkg.sv
//------------------------------------------------------------------------------
// Module  : pid_fan_pkg
// Purpose : Shared types and helpers for the fan PID -> PWM output stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pid_fan_pkg;

    localparam int DEFAULT_ADC_BITWIDTH = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } fan_state_e;

    // Full-scale PWM duty for a given magnitude width.
    function automatic int pwm_max(input int width);
        return (1 << width) - 1;
    endfunction

    // Converts the sign-extended PID output into an unsigned duty request:
    // negative demand means off, small positive demand is lifted to the floor
    // so the fan is never asked to spin too slowly to start.
    function automatic int clamp_duty(input int duty, input int min_duty, input int width);
        if (duty < 0) begin
            return 0;
        end else if ((duty > 0) && (duty < min_duty)) begin
            return min_duty;
        end else begin
            return duty & pwm_max(width);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_tick_gen.sv
//------------------------------------------------------------------------------
// Module  : pwm_tick_gen
// Purpose : Prescaler and PWM step counter; flags the last step of a period.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_tick_gen
    import pid_fan_pkg::*;
#(
    parameter int ADC_BITWIDTH = DEFAULT_ADC_BITWIDTH,
    parameter int PWM_PRESCALE = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    output logic [ADC_BITWIDTH-1:0] step_o,
    output logic                    tick_o,
    output logic                    boundary_o
);

    localparam logic [ADC_BITWIDTH-1:0] STEP_LAST = ADC_BITWIDTH'(pwm_max(ADC_BITWIDTH) - 1);

    logic [ADC_BITWIDTH-1:0] step_q;

    generate
        if (PWM_PRESCALE > 1) begin : g_prescaler
            localparam int            PW         = $clog2(PWM_PRESCALE);
            localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESCALE - 1);

            logic [PW-1:0] presc_q;

            // Prescaler: free-runs 0..PWM_PRESCALE-1 while enabled, parked at 0 otherwise.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    presc_q <= '0;
                end else if (!en_i || (presc_q == PRESC_LAST)) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end

            assign tick_o = en_i && (presc_q == PRESC_LAST);
        end else begin : g_no_prescaler
            assign tick_o = en_i;
        end
    endgenerate

    // Step counter: advances once per tick and wraps after the last PWM step.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            step_q <= '0;
        end else if (!en_i) begin
            step_q <= '0;
        end else if (tick_o) begin
            step_q <= (step_q == STEP_LAST) ? '0 : step_q + ADC_BITWIDTH'(1);
        end
    end

    assign step_o     = step_q;
    assign boundary_o = tick_o && (step_q == STEP_LAST);

endmodule

`default_nettype wire

// File: rtl/pid_pwm_gen.sv
//------------------------------------------------------------------------------
// Module  : pid_pwm_gen
// Purpose : Converts the signed PID output into a glitch-free fan PWM with a
//           full-duty start-up kick when leaving standstill.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pid_pwm_gen
    import pid_fan_pkg::*;
#(
    parameter int ADC_BITWIDTH = DEFAULT_ADC_BITWIDTH,
    parameter int PWM_PRESCALE = 4,
    parameter int MIN_DUTY     = 32,
    parameter int KICK_PERIODS = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic [ADC_BITWIDTH:0]   duty_i,
    input  logic                    duty_valid_i,
    output logic                    pwm_o,
    output logic                    period_end_o,
    output logic [ADC_BITWIDTH-1:0] duty_o,
    output logic                    kick_active_o
);

    localparam logic [ADC_BITWIDTH-1:0] DUTY_FULL = ADC_BITWIDTH'(pwm_max(ADC_BITWIDTH));
    localparam int                      KW        = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam logic [KW-1:0]           KICK_INIT = KW'(KICK_PERIODS - 1);

    logic [ADC_BITWIDTH-1:0] w_step;
    logic                    w_tick;
    logic                    w_boundary;
    logic [ADC_BITWIDTH-1:0] w_conv;

    logic [ADC_BITWIDTH-1:0] pending_d;
    logic [ADC_BITWIDTH-1:0] pending_q;
    fan_state_e              state_q;
    logic [ADC_BITWIDTH-1:0] duty_q;
    logic [KW-1:0]           kick_cnt_q;
    logic                    kick_active_q;
    logic                    pwm_q;
    logic                    period_end_q;

    pwm_tick_gen #(
        .ADC_BITWIDTH (ADC_BITWIDTH),
        .PWM_PRESCALE (PWM_PRESCALE)
    ) u_tick (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .en_i       (en_i),
        .step_o     (w_step),
        .tick_o     (w_tick),
        .boundary_o (w_boundary)
    );

    assign w_conv = ADC_BITWIDTH'(clamp_duty(int'($signed(duty_i)), MIN_DUTY, ADC_BITWIDTH));

    // A strobe landing on the boundary cycle is used directly, so the new
    // demand is not delayed by a whole period.
    assign pending_d = duty_valid_i ? w_conv : pending_q;

    // Pending demand: captured on every strobe, independent of the enable.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Fan state machine and applied duty: only moves on a period boundary.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= ST_OFF;
            duty_q        <= '0;
            kick_cnt_q    <= '0;
            kick_active_q <= 1'b0;
        end else if (!en_i) begin
            state_q       <= ST_OFF;
            duty_q        <= '0;
            kick_cnt_q    <= '0;
            kick_active_q <= 1'b0;
        end else if (w_boundary) begin
            case (state_q)
                ST_OFF: begin
                    if (pending_d != '0) begin
                        state_q       <= ST_KICK;
                        duty_q        <= DUTY_FULL;
                        kick_cnt_q    <= KICK_INIT;
                        kick_active_q <= 1'b1;
                    end else begin
                        duty_q        <= '0;
                    end
                end
                ST_KICK: begin
                    if (pending_d == '0) begin
                        state_q       <= ST_OFF;
                        duty_q        <= '0;
                        kick_active_q <= 1'b0;
                    end else if (kick_cnt_q == '0) begin
                        state_q       <= ST_RUN;
                        duty_q        <= pending_d;
                        kick_active_q <= 1'b0;
                    end else begin
                        kick_cnt_q    <= kick_cnt_q - KW'(1);
                        duty_q        <= DUTY_FULL;
                    end
                end
                ST_RUN: begin
                    if (pending_d == '0) begin
                        state_q       <= ST_OFF;
                        duty_q        <= '0;
                    end else begin
                        duty_q        <= pending_d;
                    end
                end
                default: begin
                    state_q       <= ST_OFF;
                    duty_q        <= '0;
                    kick_active_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered PWM compare and end-of-period pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            pwm_q        <= en_i && (w_step < duty_q);
            period_end_q <= en_i && w_boundary;
        end
    end

    assign pwm_o         = pwm_q;
    assign period_end_o  = period_end_q;
    assign duty_o        = duty_q;
    assign kick_active_o = kick_active_q;

endmodule

`default_nettype wire

// File: doc/pid_pwm_gen.md
Name: pid_pwm_gen

Overview:
Downstream stage of the fan PID controller. Takes the signed controller output and converts it into a fan PWM signal.
- Negative demand clamps to 0.
- A non-zero demand below MIN_DUTY is raised to MIN_DUTY.
- Duty changes apply only at PWM period boundaries, so pulses never glitch.
- A fan starting from standstill gets a full-duty kick for KICK_PERIODS periods before running at the requested duty.

Parameters:
ADC_BITWIDTH, 8, magnitude width of the duty value; PWM resolution is 2^ADC_BITWIDTH-1 steps.
PWM_PRESCALE, 4, clk_i cycles per PWM counter step (≥1).
MIN_DUTY, 32, floor applied to any non-zero demand (1..2^ADC_BITWIDTH-1).
KICK_PERIODS, 16, number of full-duty periods when leaving OFF (≥1).

Ports:
clk_i  in  1  system clock.
rstn_i  in  1  asynchronous active-low reset.
en_i  in  1  block enable; low forces an idle state.
duty_i  in  ADC_BITWIDTH+1  signed PID output (two's complement).
duty_valid_i  in  1  one-cycle strobe; duty_i is valid in this cycle.
pwm_o  out  1  registered PWM output to the fan driver.
period_end_o  out  1  one-cycle pulse in the last clock of each PWM period.
duty_o  out  ADC_BITWIDTH  duty currently applied.
kick_active_o  out  1  high while the state is KICK.

Behaviour:
- Reset (asynchronous, rstn_i low) puts every register in its idle value:
  - pwm_o=0, period_end_o=0, duty_o=0, kick_active_o=0.
  - Prescaler=0, step counter=0, state=OFF, pending=0, kick counter=0.
- Input conversion, on duty_valid_i: pending <= 0 if duty_i<0; else MIN_DUTY if 0<duty_i<MIN_DUTY; else duty_i[ADC_BITWIDTH-1:0].
- Without a strobe, pending holds its value.
- Prescaler:
  - Counts 0..PWM_PRESCALE-1 while en_i=1.
  - tick = (prescaler==PWM_PRESCALE-1).
  - PWM_PRESCALE=1 means tick every cycle.
- Step counter:
  - Counts 0..PWM_MAX-1 on tick, where PWM_MAX=2^ADC_BITWIDTH-1, then wraps to 0.
  - Period = PWM_MAX*PWM_PRESCALE clocks (1020 clocks at defaults).
- Boundary: a cycle where tick=1 and step==PWM_MAX-1.
  - period_end_o is registered and asserts in the cycle after the boundary condition, aligned with step 0 of the new period.
  - The state machine and duty_o update at the boundary clock edge.
- pwm_o is registered: pwm_o(t+1) = en_i(t) && (step(t) < duty_o(t)).
  - duty 0 gives constant low; duty PWM_MAX gives constant high.
- State machine (transitions only at the boundary):
  - OFF: duty_o=0. If pending≠0, go to KICK, set duty_o=PWM_MAX and kick counter=KICK_PERIODS-1.
  - KICK: duty_o=PWM_MAX.
    - If pending==0: go to OFF, duty_o=0.
    - Else if kick counter==0: go to RUN, duty_o=pending.
    - Else decrement the kick counter.
  - RUN: if pending==0, go to OFF with duty_o=0; else duty_o=pending.
  - kick_active_o = (state==KICK), registered alongside the state.
- Strobe coincident with the boundary: the newly converted value is used at that boundary (bypass of pending).
- en_i low, taking effect synchronously on the next edge:
  - Prescaler and step counter go to 0.
  - State=OFF, duty_o=0, pwm_o=0, period_end_o=0.
  - pending keeps its value and duty_valid_i is still accepted.
- en_i rising: counting restarts from step 0. A non-zero pending enters KICK at the first boundary.
- Reset mid-period: immediate idle as above; no partial pulse after reset is released.

Decomposition:
- Package pid_fan_pkg holds:
  - State encoding enum: OFF=2'd0, KICK=2'd1, RUN=2'd2.
  - Default ADC_BITWIDTH.
  - Function pwm_max(width) = 2^width-1.
  - Function clamp_duty for the input conversion.
- One natural sub-module, pwm_tick_gen:
  - Contains the prescaler plus step counter.
  - Outputs step, tick and boundary; inputs are clk_i, rstn_i, en_i.
- FSM, duty registers and output compare stay in pid_pwm_gen.

Test Plan:
- Defaults except KICK_PERIODS=2, en_i=1. Strobe duty_i=128 while in OFF → at the next boundary kick_active_o=1 and pwm_o high for 2 full periods (2040 clks). Then RUN with duty_o=128, pwm_o high 512 clks of each 1020-clk period.
- In RUN, strobe duty_i=-5 → duty_o=0 at the next boundary, state OFF, pwm_o constantly low, no kick.
- In RUN at duty 128, strobe duty_i=10 → duty_o=32 (MIN_DUTY) at the next boundary, pwm_o high 128 clks per period. Strobe duty_i=255 → pwm_o constantly high.
- Strobe duty_i=200 in the same cycle as the boundary condition while in RUN → duty_o=200 from that boundary; no period with the old duty after it.
- Strobe duty_i=0 during KICK → at the next boundary state OFF, kick_active_o=0, duty_o=0.
- Drop en_i mid-period, then rstn_i low mid-pulse → pwm_o=0 and step=0 on the next edge after en_i drops. Reset forces all outputs to 0 asynchronously, before any clock edge. After release with en_i=1 and pending=0, pwm_o stays low.
